// File: rtl/pipe_alu.sv
// Two-stage ALU pipeline (S1 operand register -> OUT result register) with valid/ready handshakes.
// Define PIPE_ALU_MUL_EN to build the iterative shift-add multiplier for op 1110; otherwise 1110 is reserved.
module pipe_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_SLT  = 4'b0100,
    OP_SLTU = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_XOR  = 4'b1001,
    OP_BEQ  = 4'b1010,
    OP_BNE  = 4'b1011,
    OP_BLT  = 4'b1100,
    OP_BGE  = 4'b1101,
    OP_MUL  = 4'b1110,
    OP_RSVD = 4'b1111
  } op_e;

  // S1 stage
  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  // OUT stage
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             branch_q, branch_d;

  logic             accept;
  logic             s1_adv;
  logic             mul_ok;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_br;

`ifdef PIPE_ALU_MUL_EN
  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_e;

  mul_state_e       mul_state_q;
  logic [WIDTH-1:0] mul_acc_q;
  logic [WIDTH-1:0] mul_mcand_q;
  logic [WIDTH-1:0] mul_mplier_q;
  logic [SHW-1:0]   mul_cnt_q;

  // A MUL in S1 may only leave once the product is final.
  assign mul_ok = (s1_op_q != OP_MUL) || (mul_state_q == MUL_DONE);

  // The FSM starts on the accept edge itself, so BUSY covers the WIDTH edges that follow.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_state_q <= MUL_IDLE;
    end else if (accept && (op == OP_MUL)) begin
      mul_state_q  <= MUL_BUSY;
      mul_acc_q    <= '0;
      mul_mcand_q  <= a;
      mul_mplier_q <= b;
      mul_cnt_q    <= '0;
    end else begin
      case (mul_state_q)
        MUL_BUSY: begin
          if (mul_mplier_q[0]) begin
            mul_acc_q <= mul_acc_q + mul_mcand_q;
          end
          mul_mcand_q  <= mul_mcand_q << 1;
          mul_mplier_q <= mul_mplier_q >> 1;
          mul_cnt_q    <= mul_cnt_q + SHW'(1);
          if (mul_cnt_q == SHW'(WIDTH - 1)) begin
            mul_state_q <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          if (s1_adv) begin
            mul_state_q <= MUL_IDLE;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign mul_ok = 1'b1;
`endif

  assign s1_adv   = s1_valid_q && mul_ok && (!out_valid_q || out_ready);
  assign in_ready = !rst && (!s1_valid_q || s1_adv);
  assign accept   = in_valid && in_ready;
  assign shamt    = s1_b_q[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (s1_op_q)
      OP_AND:  alu_res = s1_a_q & s1_b_q;
      OP_OR:   alu_res = s1_a_q | s1_b_q;
      OP_ADD:  alu_res = s1_a_q + s1_b_q;
      OP_SUB:  alu_res = s1_a_q - s1_b_q;
      OP_SLT:  alu_res = WIDTH'($signed(s1_a_q) < $signed(s1_b_q));
      OP_SLTU: alu_res = WIDTH'(s1_a_q < s1_b_q);
      OP_SLL:  alu_res = s1_a_q << shamt;
      OP_SRL:  alu_res = s1_a_q >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(s1_a_q) >>> shamt);
      OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
      OP_BEQ:  alu_br  = (s1_a_q == s1_b_q);
      OP_BNE:  alu_br  = (s1_a_q != s1_b_q);
      OP_BLT:  alu_br  = ($signed(s1_a_q) <  $signed(s1_b_q));
      OP_BGE:  alu_br  = ($signed(s1_a_q) >= $signed(s1_b_q));
`ifdef PIPE_ALU_MUL_EN
      OP_MUL:  alu_res = mul_acc_q;
`endif
      default: ;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // OUT keeps its contents after a handshake; only the valid flag drops.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    branch_d    = branch_q;
    if (s1_adv) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      branch_d    = alu_br;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      branch_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      branch_q    <= branch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op_q <= op_e'(op);
      s1_a_q  <= a;
      s1_b_q  <= b;
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign branch_taken = branch_q;

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have one clock and a synchronous, active-high reset (ports clk, rst); no other clock or reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operation presented.
REQ-007 SHALL have port in_ready  output  1  operation accepted this edge when high with in_valid.
REQ-008 SHALL have port op  input  4  operation code (REQ-012).
REQ-009 SHALL have ports a and b  input  WIDTH  operands.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have ports out_ready  input  1  consumer accepts; result  output  WIDTH  result; branch_taken  output  1  compare outcome.

Function
REQ-012 SHALL use these op codes:
- 0000 AND; 0001 OR; 0010 ADD; 0011 SUB; 0100 SLT (signed); 0101 SLTU; 0110 SLL; 0111 SRL; 1000 SRA; 1001 XOR
- 1010 BEQ; 1011 BNE; 1100 BLT (signed); 1101 BGE (signed)
- 1110 MUL; 1111 reserved
REQ-013 SHALL use shift amount b[SHW-1:0] and ignore the upper bits of b.
REQ-014 SHALL wrap ADD/SUB/MUL modulo 2^WIDTH, with MUL returning the low WIDTH bits of the product.
REQ-015 SHALL return result 1 or 0 for SLT/SLTU, with branch_taken 0.
REQ-016 SHALL return result 0 and branch_taken equal to the compare outcome for branch ops.
REQ-017 SHALL return branch_taken 0 for all non-branch ops.
REQ-018 SHALL return result 0 and branch_taken 0 for reserved op 1111.
REQ-019 SHALL be a two-register pipeline: S1 (operand/op register), then OUT (result register).
REQ-020 SHALL transfer a handshake only on a rising edge where valid and ready are both high.
REQ-021 SHALL register a, b and op into S1 on input accept.
REQ-022 SHALL, for non-MUL ops, assert out_valid with the result after the edge following accept (latency 2 edges).
REQ-023 SHALL sustain throughput of 1 op/cycle while out_ready is held high.
REQ-024 SHALL advance S1 into OUT when S1 is full, any MUL is complete, and (OUT is empty or out_ready is high).
REQ-025 SHALL drive in_ready = !rst && (S1 empty || S1 advancing this edge).
REQ-026 SHALL hold result, branch_taken and out_valid stable while out_valid is high and out_ready is low.
REQ-027 SHALL deliver results strictly in accept order, with no loss or duplication under any backpressure pattern.
REQ-028 SHALL allow a simultaneous output handshake and input accept in one edge, with no bubble inserted.
REQ-029 SHALL implement the MUL state machine as IDLE -> BUSY (shift-add, one multiplier bit per cycle, WIDTH cycles) -> DONE -> IDLE once S1 advances.
REQ-030 SHALL keep S1 occupied during BUSY so that in_ready is low; MUL latency is WIDTH+2 edges from accept to out_valid.

Reset
REQ-031 SHALL, on any edge with rst high, clear out_valid, result, branch_taken and the S1 valid flag, and set the MUL FSM to IDLE.
REQ-032 SHALL discard in-flight operations, including a MUL mid-BUSY, with no output produced for them.
REQ-033 SHALL drive in_ready low while rst is high.
REQ-034 SHALL accept a new operation on the first edge after rst deasserts.

Configuration
REQ-035 SHALL compile in the multiplier (REQ-029, REQ-030) when macro PIPE_ALU_MUL_EN is defined.
REQ-036 SHALL, without PIPE_ALU_MUL_EN, omit the MUL FSM and datapath and treat op 1110 as reserved (result 0, branch_taken 0, latency 2).

Verification (WIDTH=32, out_ready=1 unless stated)
REQ-037 SHALL check: ADD a=10000, b=111 -> result 10111, out_valid 2 edges after accept; ADD 0xFFFFFFFF+1 -> 0.
REQ-038 SHALL check: back-to-back AND 0x0F,0x55; XOR 0x55,0xFF; SRA 0x80000000,33, with out_ready low for 3 cycles -> in_ready drops after 2 accepts, results 0x05, 0xAA, 0xC0000000 in order, held stable while stalled.
REQ-039 SHALL check: BLT a=0xFFFFFFFF, b=1 -> branch_taken 1, result 0; SLTU same operands -> result 0, branch_taken 0; BEQ 5,5 -> branch_taken 1.
REQ-040 SHALL check, with PIPE_ALU_MUL_EN: MUL 0xFFFF*0xFFFF -> 0xFFFE0001 at 34 edges after accept, in_ready low throughout BUSY; without the macro -> result 0 at latency 2.
REQ-041 SHALL check: rst asserted mid-MUL BUSY -> out_valid 0 and in_ready 0 while rst is high, no stale result; then ADD 1+0x10000 -> 0x10001.
